// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the two-port data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam logic [1:0] MODE_BYTE    = 2'b00;
    localparam logic [1:0] MODE_HALF    = 2'b01;
    localparam logic [1:0] MODE_WORD    = 2'b10;
    localparam logic [1:0] MODE_ILLEGAL = 2'b11;

    // Memory control value presented whenever the port is idle.
    localparam logic [2:0] CTRL_IDLE = {1'b0, MODE_WORD};

    function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [1:0] mode);
        case (mode)
            MODE_HALF: is_misaligned = addr_lo[0];
            MODE_WORD: is_misaligned = (addr_lo != 2'b00);
            default:   is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signals of the data-memory arbiter.
interface dmem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    import dmem_arb_pkg::*;

    logic                  req0, req1;
    logic [ADDR_WIDTH-1:0] addr0, addr1;
    logic                  we0, we1;
    logic [2:0]            ctrl0, ctrl1;
    logic [DATA_WIDTH-1:0] wdata0, wdata1;
    logic                  done0, done1;
    logic                  err0, err1;
    logic [DATA_WIDTH-1:0] rdata;

    logic [ADDR_WIDTH-1:0] mem_A;
    logic                  mem_WE;
    logic [2:0]            mem_ctrl;
    logic [DATA_WIDTH-1:0] mem_WD;
    logic [DATA_WIDTH-1:0] mem_RD;

    modport slave (
        input  req0, req1, addr0, addr1, we0, we1, ctrl0, ctrl1, wdata0, wdata1, mem_RD,
        output done0, done1, err0, err1, rdata, mem_A, mem_WE, mem_ctrl, mem_WD
    );

    modport master (
        output req0, req1, addr0, addr1, we0, we1, ctrl0, ctrl1, wdata0, wdata1, mem_RD,
        input  done0, done1, err0, err1, rdata, mem_A, mem_WE, mem_ctrl, mem_WD
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick; ptr_i names the port that wins a tie.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = ptr_i ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the CPU LSU (port 0) and the DMA/loader (port 1).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);

    localparam int            CW       = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic          WE_FIRST = (MEM_LATENCY == 1);

    state_e                state_q;
    logic                  ptr_q;
    logic                  port_q;
    logic                  we_q;
    logic [CW-1:0]         cnt_q;
    logic                  done0_q, done1_q, err0_q, err1_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [ADDR_WIDTH-1:0] mem_A_q;
    logic                  mem_WE_q;
    logic [2:0]            mem_ctrl_q;
    logic [DATA_WIDTH-1:0] mem_WD_q;

    logic [1:0]            gnt;
    logic                  sel_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic                  we_d;
    logic [2:0]            ctrl_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic                  reject_d;

    rr_arb2 u_arb (
        .req_i ({bus.req1, bus.req0}),
        .ptr_i (ptr_q),
        .gnt_o (gnt)
    );

    assign sel_d    = gnt[1];
    assign addr_d   = sel_d ? bus.addr1  : bus.addr0;
    assign we_d     = sel_d ? bus.we1    : bus.we0;
    assign ctrl_d   = sel_d ? bus.ctrl1  : bus.ctrl0;
    assign wdata_d  = sel_d ? bus.wdata1 : bus.wdata0;
    assign reject_d = (ctrl_d[1:0] == MODE_ILLEGAL) || is_misaligned(addr_d[1:0], ctrl_d[1:0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            port_q     <= 1'b0;
            we_q       <= 1'b0;
            cnt_q      <= '0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
            rdata_q    <= '0;
            mem_A_q    <= '0;
            mem_WE_q   <= 1'b0;
            mem_ctrl_q <= CTRL_IDLE;
            mem_WD_q   <= '0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|gnt) begin
                        ptr_q  <= ~sel_d;
                        port_q <= sel_d;
                        we_q   <= we_d;
                        // Rejected accesses skip the memory entirely and answer next cycle.
                        if (reject_d) begin
                            state_q <= DONE;
                            done0_q <= ~sel_d;
                            done1_q <= sel_d;
                            err0_q  <= ~sel_d;
                            err1_q  <= sel_d;
                        end else begin
                            state_q    <= ACCESS;
                            cnt_q      <= CNT_INIT;
                            mem_A_q    <= addr_d;
                            mem_ctrl_q <= ctrl_d;
                            mem_WD_q   <= wdata_d;
                            mem_WE_q   <= we_d && WE_FIRST;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt_q == '0) begin
                        if (!we_q) rdata_q <= bus.mem_RD;
                        state_q    <= DONE;
                        done0_q    <= ~port_q;
                        done1_q    <= port_q;
                        mem_A_q    <= '0;
                        mem_ctrl_q <= CTRL_IDLE;
                        mem_WD_q   <= '0;
                        mem_WE_q   <= 1'b0;
                    end else begin
                        // WE is registered, so raise it one edge ahead of the final access cycle.
                        cnt_q    <= cnt_q - 1'b1;
                        mem_WE_q <= we_q && (cnt_q == CNT_ONE);
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.done0    = done0_q;
    assign bus.done1    = done1_q;
    assign bus.err0     = err0_q;
    assign bus.err1     = err1_q;
    assign bus.rdata    = rdata_q;
    assign bus.mem_A    = mem_A_q;
    // Masking with rst_n keeps a reset on the final access edge from landing a write.
    assign bus.mem_WE   = mem_WE_q & rst_n;
    assign bus.mem_ctrl = mem_ctrl_q;
    assign bus.mem_WD   = mem_WD_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: one arbiter with MEM_LATENCY=1 and one with MEM_LATENCY=3, each on a byte memory model.
module tb_dmem_arbiter;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   wea = 0;
    int   web = 0;

    dmem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifa ();
    dmem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifb ();

    dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(3)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  mem_a [0:131071];
    logic [7:0]  mem_b [0:131071];
    logic [16:0] ia, ib;

    assign ia = ifa.mem_A[16:0];
    assign ib = ifb.mem_A[16:0];

    function automatic logic [31:0] rd_fmt(input logic [31:0] w, input logic [2:0] c);
        case (c[1:0])
            2'b00:   rd_fmt = c[2] ? {24'h0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
            2'b01:   rd_fmt = c[2] ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
            default: rd_fmt = w;
        endcase
    endfunction

    always_comb ifa.mem_RD = rd_fmt({mem_a[ia+17'd3], mem_a[ia+17'd2], mem_a[ia+17'd1], mem_a[ia]}, ifa.mem_ctrl);
    always_comb ifb.mem_RD = rd_fmt({mem_b[ib+17'd3], mem_b[ib+17'd2], mem_b[ib+17'd1], mem_b[ib]}, ifb.mem_ctrl);

    always @(posedge clk) begin
        if (ifa.mem_WE) begin
            wea++;
            mem_a[ia] <= ifa.mem_WD[7:0];
            if (ifa.mem_ctrl[1:0] != 2'b00) mem_a[ia+17'd1] <= ifa.mem_WD[15:8];
            if (ifa.mem_ctrl[1:0] == 2'b10) begin
                mem_a[ia+17'd2] <= ifa.mem_WD[23:16];
                mem_a[ia+17'd3] <= ifa.mem_WD[31:24];
            end
        end
        if (ifb.mem_WE) begin
            web++;
            mem_b[ib] <= ifb.mem_WD[7:0];
            if (ifb.mem_ctrl[1:0] != 2'b00) mem_b[ib+17'd1] <= ifb.mem_WD[15:8];
            if (ifb.mem_ctrl[1:0] == 2'b10) begin
                mem_b[ib+17'd2] <= ifb.mem_WD[23:16];
                mem_b[ib+17'd3] <= ifb.mem_WD[31:24];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic setreq(input bit b, input bit p, input bit r, input logic [31:0] a,
                          input bit w, input logic [2:0] c, input logic [31:0] d);
        if (!b && !p) begin
            ifa.req0 = r; ifa.addr0 = a; ifa.we0 = w; ifa.ctrl0 = c; ifa.wdata0 = d;
        end else if (!b) begin
            ifa.req1 = r; ifa.addr1 = a; ifa.we1 = w; ifa.ctrl1 = c; ifa.wdata1 = d;
        end else if (!p) begin
            ifb.req0 = r; ifb.addr0 = a; ifb.we0 = w; ifb.ctrl0 = c; ifb.wdata0 = d;
        end else begin
            ifb.req1 = r; ifb.addr1 = a; ifb.we1 = w; ifb.ctrl1 = c; ifb.wdata1 = d;
        end
    endtask

    task automatic drop(input bit b, input bit p);
        setreq(b, p, 1'b0, 32'h0, 1'b0, 3'b010, 32'h0);
    endtask

    // Steps until either done pulses on the selected DUT, up to a fixed budget.
    task automatic wait_done(input bit b, output int port, output int cyc);
        logic d0, d1;
        port = -1;
        cyc  = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            d0 = b ? ifb.done0 : ifa.done0;
            d1 = b ? ifb.done1 : ifa.done1;
            if (d0 || d1) begin
                port = d1 ? 1 : 0;
                cyc  = i;
                break;
            end
        end
        checks++;
        assert (port != -1) else begin
            errors++;
            $error("FAIL wait_done_timeout observed=none expected=done within 10 cycles");
        end
    endtask

    int port, cyc;

    initial begin
        for (int i = 0; i < 131072; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
        end
        mem_a[17'h40] = 8'h80;

        rst_n = 1'b0;
        drop(0, 0); drop(0, 1); drop(1, 0); drop(1, 1);
        step(); step();

        // Reset state
        chk("rst_done0",    {31'h0, ifa.done0}, 32'h0);
        chk("rst_done1",    {31'h0, ifa.done1}, 32'h0);
        chk("rst_err",      {30'h0, ifa.err1, ifa.err0}, 32'h0);
        chk("rst_rdata",    ifa.rdata, 32'h0);
        chk("rst_mem_WE",   {31'h0, ifa.mem_WE}, 32'h0);
        chk("rst_mem_A",    ifa.mem_A, 32'h0);
        chk("rst_mem_ctrl", {29'h0, ifa.mem_ctrl}, 32'h2);
        chk("rst_mem_WD",   ifa.mem_WD, 32'h0);
        rst_n = 1'b1;
        step();
        chk("idle_mem_A", ifa.mem_A, 32'h0);

        // Word store then load, MEM_LATENCY=1
        setreq(0, 0, 1'b1, 32'h0001_0000, 1'b1, 3'b010, 32'hDEAD_BEEF);
        step();
        chk("st_we_access", {31'h0, ifa.mem_WE}, 32'h1);
        chk("st_A_access",  ifa.mem_A, 32'h0001_0000);
        chk("st_WD_access", ifa.mem_WD, 32'hDEAD_BEEF);
        chk("st_no_done_early", {31'h0, ifa.done0}, 32'h0);
        step();
        chk("st_done0", {31'h0, ifa.done0}, 32'h1);
        chk("st_err0",  {31'h0, ifa.err0}, 32'h0);
        chk("st_we_off", {31'h0, ifa.mem_WE}, 32'h0);
        chk("st_A_idle", ifa.mem_A, 32'h0);
        drop(0, 0);
        step();
        chk("st_done_pulse", {31'h0, ifa.done0}, 32'h0);
        chk("st_mem_word", {mem_a[17'h10003], mem_a[17'h10002], mem_a[17'h10001], mem_a[17'h10000]}, 32'hDEAD_BEEF);
        chk("st_we_count", wea, 1);
        setreq(0, 0, 1'b1, 32'h0001_0000, 1'b0, 3'b010, 32'h0);
        step();
        chk("ld_we_low", {31'h0, ifa.mem_WE}, 32'h0);
        chk("ld_A", ifa.mem_A, 32'h0001_0000);
        step();
        chk("ld_done0", {31'h0, ifa.done0}, 32'h1);
        chk("ld_rdata", ifa.rdata, 32'hDEAD_BEEF);
        drop(0, 0);
        step();

        // Contention from reset: strict 0,1,0,1 alternation
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        setreq(0, 0, 1'b1, 32'h0001_0000, 1'b0, 3'b010, 32'h0);
        setreq(0, 1, 1'b1, 32'h0000_0100, 1'b1, 3'b010, 32'h1234_5678);
        for (int k = 0; k < 4; k++) begin
            wait_done(0, port, cyc);
            chk($sformatf("rr_port_%0d", k), port, k % 2);
            chk($sformatf("rr_cycles_%0d", k), cyc, (k == 0) ? 2 : 3);
            if (k % 2 == 0) chk($sformatf("rr_rdata_%0d", k), ifa.rdata, 32'hDEAD_BEEF);
        end
        drop(0, 0); drop(0, 1);
        step();
        chk("rr_mem_word", {mem_a[17'h103], mem_a[17'h102], mem_a[17'h101], mem_a[17'h100]}, 32'h1234_5678);
        chk("rr_we_count", wea, 3);

        // Misaligned half load on port 1
        setreq(0, 1, 1'b1, 32'h0001_0001, 1'b0, 3'b001, 32'h0);
        step();
        chk("mis_done1", {31'h0, ifa.done1}, 32'h1);
        chk("mis_err1",  {31'h0, ifa.err1}, 32'h1);
        chk("mis_done0", {31'h0, ifa.done0}, 32'h0);
        chk("mis_we",    {31'h0, ifa.mem_WE}, 32'h0);
        chk("mis_A",     ifa.mem_A, 32'h0);
        drop(0, 1);
        step();
        chk("mis_pulse", {30'h0, ifa.err1, ifa.done1}, 32'h0);
        chk("mis_we_count", wea, 3);

        // Illegal mode, then lbu / lb of byte 0x80
        setreq(0, 0, 1'b1, 32'h0000_0040, 1'b1, 3'b011, 32'hFFFF_FFFF);
        step();
        chk("ill_done0", {31'h0, ifa.done0}, 32'h1);
        chk("ill_err0",  {31'h0, ifa.err0}, 32'h1);
        chk("ill_A",     ifa.mem_A, 32'h0);
        drop(0, 0);
        step();
        chk("ill_we_count", wea, 3);
        setreq(0, 0, 1'b1, 32'h0000_0040, 1'b0, 3'b100, 32'h0);
        step();
        chk("lbu_ctrl", {29'h0, ifa.mem_ctrl}, 32'h4);
        step();
        chk("lbu_done0", {31'h0, ifa.done0}, 32'h1);
        chk("lbu_err0",  {31'h0, ifa.err0}, 32'h0);
        chk("lbu_rdata", ifa.rdata, 32'h0000_0080);
        drop(0, 0);
        step();
        setreq(0, 0, 1'b1, 32'h0000_0040, 1'b0, 3'b000, 32'h0);
        step();
        step();
        chk("lb_rdata", ifa.rdata, 32'hFFFF_FF80);
        drop(0, 0);
        step();

        // MEM_LATENCY=3 store
        setreq(1, 0, 1'b1, 32'h0000_0020, 1'b1, 3'b010, 32'hCAFE_F00D);
        step();
        chk("l3_A_c1",  ifb.mem_A, 32'h20);
        chk("l3_we_c1", {31'h0, ifb.mem_WE}, 32'h0);
        step();
        chk("l3_A_c2",  ifb.mem_A, 32'h20);
        chk("l3_we_c2", {31'h0, ifb.mem_WE}, 32'h0);
        step();
        chk("l3_A_c3",  ifb.mem_A, 32'h20);
        chk("l3_we_c3", {31'h0, ifb.mem_WE}, 32'h1);
        chk("l3_no_done_c3", {31'h0, ifb.done0}, 32'h0);
        step();
        chk("l3_done0", {31'h0, ifb.done0}, 32'h1);
        chk("l3_we_off", {31'h0, ifb.mem_WE}, 32'h0);
        chk("l3_A_idle", ifb.mem_A, 32'h0);
        drop(1, 0);
        step();
        chk("l3_mem_word", {mem_b[17'h23], mem_b[17'h22], mem_b[17'h21], mem_b[17'h20]}, 32'hCAFE_F00D);
        chk("l3_we_count", web, 1);

        // Reset during first ACCESS cycle of a MEM_LATENCY=3 store
        setreq(1, 0, 1'b1, 32'h0000_0030, 1'b1, 3'b010, 32'h1111_1111);
        step();
        chk("ra_access_A", ifb.mem_A, 32'h30);
        rst_n = 1'b0;
        step();
        drop(1, 0);
        chk("ra_done0", {31'h0, ifb.done0}, 32'h0);
        chk("ra_A",     ifb.mem_A, 32'h0);
        chk("ra_we",    {31'h0, ifb.mem_WE}, 32'h0);
        chk("ra_ctrl",  {29'h0, ifb.mem_ctrl}, 32'h2);
        rst_n = 1'b1;
        step();
        chk("ra_no_late_done", {31'h0, ifb.done0}, 32'h0);
        step(); step();
        chk("ra_no_late_done2", {31'h0, ifb.done0}, 32'h0);
        chk("ra_we_count", web, 1);
        chk("ra_mem_word", {mem_b[17'h33], mem_b[17'h32], mem_b[17'h31], mem_b[17'h30]}, 32'h0);
        setreq(1, 0, 1'b1, 32'h0000_0020, 1'b0, 3'b010, 32'h0);
        setreq(1, 1, 1'b1, 32'h0000_0030, 1'b0, 3'b010, 32'h0);
        wait_done(1, port, cyc);
        chk("ra_ptr_port", port, 0);
        chk("ra_ptr_cycles", cyc, 4);
        chk("ra_ptr_rdata", ifb.rdata, 32'hCAFE_F00D);
        drop(1, 0); drop(1, 1);
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
